// File: rtl/gt_io_pkg.sv
// Shared definitions for the Gambling_Tec memory-mapped I/O peripheral:
// register offsets, LFSR taps, decoded register select and helpers.
package gt_io_pkg;

   localparam logic [4:0] OFF_RNG   = 5'h00;
   localparam logic [4:0] OFF_TIMER = 5'h04;
   localparam logic [4:0] OFF_BTN   = 5'h08;
   localparam logic [4:0] OFF_LED   = 5'h0C;
   localparam logic [4:0] OFF_SCORE = 5'h10;

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_RNG,
      REG_TIMER,
      REG_BTN,
      REG_LED,
      REG_SCORE
   } io_reg_e;

   // Galois right-shift step; the map is invertible, so a nonzero state never reaches 0.
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
   endfunction

   function automatic io_reg_e decode(input logic [4:0] off);
      io_reg_e sel;
      case ({off[4:2], 2'b00})
         OFF_RNG:   sel = REG_RNG;
         OFF_TIMER: sel = REG_TIMER;
         OFF_BTN:   sel = REG_BTN;
         OFF_LED:   sel = REG_LED;
         OFF_SCORE: sel = REG_SCORE;
         default:   sel = REG_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/gt_io_periph_if.sv
// CPU data-bus view of the I/O peripheral: address, write data, strobe,
// and the combinational read data / window-hit returned to the top-level mux.
interface gt_io_periph_if;
   logic [31:0] addr;
   logic [31:0] wd;
   logic        we;
   logic [31:0] rd;
   logic        hit;

   modport master (output addr, output wd, output we, input rd, input hit);
   modport slave  (input addr, input wd, input we, output rd, output hit);
endinterface

// File: rtl/gt_io_periph_btn_sync_edge.sv
// Two-flop synchronizer per button bit plus a third flop for rising-edge detection.
module btn_sync_edge #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] rise
);

   logic [W-1:0] s1_q, s2_q, s3_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/gt_io_periph.sv
// Memory-mapped I/O peripheral beside data_mem: RNG, tick timer, sticky
// button edge flags, LED and score registers in a 32-byte window.
module gt_io_periph
   import gt_io_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
   parameter int unsigned NUM_BTN   = 4,
   parameter int unsigned TICK_DIV  = 50_000,
   parameter logic [31:0] LFSR_SEED = 32'hACE1_2025
) (
   input  logic               clk,
   input  logic               rst,
   gt_io_periph_if.slave      bus,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [7:0]         leds,
   output logic [15:0]        score
);

   localparam logic [31:0] PRE_LAST = 32'(TICK_DIV - 1);

   logic [31:0]        off;
   logic               hit;
   io_reg_e            sel;
   logic               wr;
   logic [NUM_BTN-1:0] rise;
   logic               tick;

   logic [31:0]        lfsr_q, lfsr_d;
   logic [31:0]        presc_q, presc_d;
   logic [31:0]        timer_q, timer_d;
   logic [NUM_BTN-1:0] flags_q, flags_d;
   logic [7:0]         leds_q, leds_d;
   logic [15:0]        score_q, score_d;

   // Addresses below the base wrap to large offsets, so one compare bounds both ends.
   assign off = bus.addr - BASE_ADDR;
   assign hit = (off[31:5] == '0);
   assign sel = hit ? decode(off[4:0]) : REG_NONE;
   assign wr  = bus.we && hit;

   btn_sync_edge #(.W(NUM_BTN)) u_btn (
      .clk  (clk),
      .rst  (rst),
      .d    (btn_in),
      .rise (rise)
   );

   assign tick = (presc_q == PRE_LAST);

   always_comb begin
      lfsr_d  = lfsr_next(lfsr_q);
      presc_d = tick ? '0 : presc_q + 32'd1;
      timer_d = tick ? timer_q + 32'd1 : timer_q;
      flags_d = flags_q;
      leds_d  = leds_q;
      score_d = score_q;
      if (wr) begin
         case (sel)
            REG_RNG:   lfsr_d = (bus.wd == '0) ? LFSR_SEED : bus.wd;
            REG_TIMER: begin
               presc_d = '0;
               timer_d = '0;
            end
            REG_BTN:   flags_d = flags_q & ~bus.wd[NUM_BTN-1:0];
            REG_LED:   leds_d  = bus.wd[7:0];
            REG_SCORE: score_d = bus.wd[15:0];
            default:   ;
         endcase
      end
      // Applied after the clear so a coincident edge keeps its flag.
      flags_d = flags_d | rise;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q  <= LFSR_SEED;
         presc_q <= '0;
         timer_q <= '0;
         flags_q <= '0;
         leds_q  <= '0;
         score_q <= '0;
      end else begin
         lfsr_q  <= lfsr_d;
         presc_q <= presc_d;
         timer_q <= timer_d;
         flags_q <= flags_d;
         leds_q  <= leds_d;
         score_q <= score_d;
      end
   end

   always_comb begin
      bus.rd = '0;
      case (sel)
         REG_RNG:   bus.rd = lfsr_q;
         REG_TIMER: bus.rd = timer_q;
         REG_BTN:   bus.rd[NUM_BTN-1:0] = flags_q;
         REG_LED:   bus.rd[7:0] = leds_q;
         REG_SCORE: bus.rd[15:0] = score_q;
         default:   bus.rd = '0;
      endcase
   end

   assign bus.hit = hit;
   assign leds    = leds_q;
   assign score   = score_q;

endmodule
